rng_ctrl: RTL and testbench

Controller and sampler for the 8-oscillator RNG_CELL macro.
- Powers the cell up (EN), applies the SEL trim and waits a warm-up time.
- Samples the eight asynchronous oscillator outputs in the clk domain and folds them into one raw bit per sample period.
- Packs the bits into a WIDTH-bit word and delivers it over a valid/ready interface to the entropy consumer on the system bus side.

---
 rtl/rng_ctrl_pkg.sv | 19 +
 rtl/rng_ctrl_sync.sv | 31 +++
 rtl/rng_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_rng_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_ctrl_pkg.sv
// Shared types and default constants for the RNG_CELL controller.
package rng_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    COLLECT = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_SAMPLE_DIV = 16;
  localparam int DEF_WARMUP_CYC = 256;
  localparam int DEF_HEALTH_RPT = 24;

  localparam int SEL_W = 3;
  localparam int N_OSC = 8;

endpackage

// File: rtl/rng_ctrl_sync.sv
// N-bit two-flop synchroniser for the free-running oscillator outputs.
module rng_ctrl_sync #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta_q, meta_d;
  logic [N-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rng_ctrl.sv
// RNG_CELL controller: power-up, warm-up, raw-bit sampling and word delivery.
// Optional repetition-count health test enabled by defining RNG_CTRL_HEALTH_EN.
module rng_ctrl
  import rng_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int WARMUP_CYC = DEF_WARMUP_CYC,
  parameter int HEALTH_RPT = DEF_HEALTH_RPT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [SEL_W-1:0] sel_cfg,
  output logic             rng_en,
  output logic [SEL_W-1:0] rng_sel,
  input  logic [N_OSC-1:0] rng_in,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             health_fail
);

  localparam int WU_W = $clog2(WARMUP_CYC) + 1;
  localparam int SC_W = $clog2(SAMPLE_DIV) + 1;
  localparam int BC_W = $clog2(WIDTH) + 1;

  localparam logic [WU_W-1:0] WU_LOAD = WU_W'(WARMUP_CYC - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SAMPLE_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic               rng_en_q, rng_en_d;
  logic [SEL_W-1:0]   rng_sel_q, rng_sel_d;
  logic [WU_W-1:0]    wu_cnt_q, wu_cnt_d;
  logic [SC_W-1:0]    samp_cnt_q, samp_cnt_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-2:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   sr_next;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic [N_OSC-1:0]   rng_in_s;
  logic               raw_bit;
  logic               block_word;

  rng_ctrl_sync #(.N(N_OSC)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rng_in),
    .q     (rng_in_s)
  );

  assign raw_bit = ^rng_in_s;

`ifdef RNG_CTRL_HEALTH_EN
  localparam int RC_W = $clog2(HEALTH_RPT) + 1;
  localparam logic [RC_W-1:0] RPT_LIM = RC_W'(HEALTH_RPT);

  logic            sample_tick;
  logic [RC_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            last_bit_q, last_bit_d;
  logic            health_q, health_d;

  assign sample_tick = (state_q == COLLECT) && enable && (samp_cnt_q == SC_LAST);

  always_comb begin
    rep_cnt_d  = rep_cnt_q;
    last_bit_d = last_bit_q;
    health_d   = health_q;
    if (state_q == IDLE) begin
      rep_cnt_d = '0;
    end else if (sample_tick) begin
      last_bit_d = raw_bit;
      // A zero count means no bit seen yet since the last pass through IDLE.
      if ((rep_cnt_q != '0) && (raw_bit == last_bit_q)) begin
        if (rep_cnt_q != RPT_LIM)
          rep_cnt_d = rep_cnt_q + RC_W'(1);
      end else begin
        rep_cnt_d = RC_W'(1);
      end
      if (rep_cnt_d == RPT_LIM)
        health_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q  <= '0;
      last_bit_q <= 1'b0;
      health_q   <= 1'b0;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      last_bit_q <= last_bit_d;
      health_q   <= health_d;
    end
  end

  assign block_word  = health_d;
  assign health_fail = health_q;
`else
  assign block_word  = 1'b0;
  // Never true for a legal limit; keeps the parameter referenced in this build.
  assign health_fail = (HEALTH_RPT < 0);
`endif

  always_comb begin
    state_d    = state_q;
    rng_en_d   = rng_en_q;
    rng_sel_d  = rng_sel_q;
    wu_cnt_d   = wu_cnt_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    sr_next    = {sr_q, raw_bit};

    case (state_q)
      IDLE: begin
        rng_en_d = 1'b0;
        if (enable) begin
          rng_sel_d = sel_cfg;
          rng_en_d  = 1'b1;
          wu_cnt_d  = WU_LOAD;
          state_d   = WARMUP;
        end
      end

      WARMUP: begin
        if (!enable) begin
          state_d  = IDLE;
          rng_en_d = 1'b0;
        end else if (wu_cnt_q == '0) begin
          samp_cnt_d = '0;
          bit_cnt_d  = '0;
          sr_d       = '0;
          state_d    = COLLECT;
        end else begin
          wu_cnt_d = wu_cnt_q - WU_W'(1);
        end
      end

      COLLECT: begin
        if (!enable) begin
          state_d    = IDLE;
          rng_en_d   = 1'b0;
          samp_cnt_d = '0;
          bit_cnt_d  = '0;
          sr_d       = '0;
        end else if (samp_cnt_q == SC_LAST) begin
          samp_cnt_d = '0;
          if (block_word) begin
            sr_d      = '0;
            bit_cnt_d = '0;
          end else if (bit_cnt_q == BC_LAST) begin
            // The word is complete with this bit; the top sr bit shifts into data.
            data_d    = sr_next;
            valid_d   = 1'b1;
            bit_cnt_d = '0;
            sr_d      = '0;
            state_d   = OUTPUT;
          end else begin
            sr_d      = sr_next[WIDTH-2:0];
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end else begin
          samp_cnt_d = samp_cnt_q + SC_W'(1);
        end
      end

      OUTPUT: begin
        if (ready) begin
          valid_d    = 1'b0;
          samp_cnt_d = '0;
          bit_cnt_d  = '0;
          if (enable) begin
            state_d = COLLECT;
          end else begin
            state_d  = IDLE;
            rng_en_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rng_en_q   <= 1'b0;
      rng_sel_q  <= '0;
      wu_cnt_q   <= '0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rng_en_q   <= rng_en_d;
      rng_sel_q  <= rng_sel_d;
      wu_cnt_q   <= wu_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign rng_en  = rng_en_q;
  assign rng_sel = rng_sel_q;
  assign data    = data_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rng_ctrl.sv
// Randomized self-checking bench for rng_ctrl; expected words come from per-period input patterns.
module tb_rng_ctrl;

  localparam int W   = 32;
  localparam int SD  = 16;
  localparam int WU  = 256;
  localparam int RPT = 24;
  localparam int LAT = 1 + WU + W * SD + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [2:0]    sel_cfg;
  logic          rng_en;
  logic [2:0]    rng_sel;
  logic [7:0]    rng_in;
  logic [W-1:0]  data;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          health_fail;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  rng_ctrl #(
    .WIDTH      (W),
    .SAMPLE_DIV (SD),
    .WARMUP_CYC (WU),
    .HEALTH_RPT (RPT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sel_cfg     (sel_cfg),
    .rng_en      (rng_en),
    .rng_sel     (rng_sel),
    .rng_in      (rng_in),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .busy        (busy),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered 1ns after the edge that starts a collection period (sample counter at 0).
  // One pattern is held per sample period, changed mid-period; each sample bit is its parity.
  // mode 0: random, 1: static pattern, 2: bit0 toggles every period starting at 0.
  task automatic run_word(input int mode, input logic [7:0] stat, output logic [W-1:0] exp_w);
    logic [7:0] p;
    exp_w = '0;
    for (int j = 0; j < W; j++) begin
      case (mode)
        0:       p = 8'($urandom);
        1:       p = stat;
        default: p = {7'b0, j[0]};
      endcase
      rng_in = p;
      exp_w  = {exp_w[W-2:0], ^p};
      if (j == 0) repeat (SD + SD / 2) tick();
      else if (j < W - 1) repeat (SD) tick();
    end
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n = 0;
    while (valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk(tag, 64'(valid), 64'(1));
  endtask

  // Enables from IDLE, checks the pin outputs and that no word appears during warm-up.
  task automatic start_run(input logic [2:0] sel, output int e0);
    int early = 0;
    sel_cfg = sel;
    enable  = 1'b1;
    tick();
    e0 = cyc;
    chk("en_after_enable", 64'(rng_en), 64'(1));
    chk("sel_latched", 64'(rng_sel), 64'(sel));
    chk("busy_after_enable", 64'(busy), 64'(1));
    sel_cfg = ~sel;
    repeat (WU) begin
      tick();
      if (valid === 1'b1) early++;
    end
    chk("no_valid_in_warmup", 64'(early), 64'(0));
  endtask

  initial begin
    logic [W-1:0] exp_w;
    int           e0;
    int           lat;
    int           bad;
    int           stall;
    int           mode_a;

    reset = 1'b1; enable = 1'b0; ready = 1'b0; rng_in = '0; sel_cfg = '0;
    repeat (3) tick();
    chk("rst_rng_en", 64'(rng_en), 64'(0));
    chk("rst_rng_sel", 64'(rng_sel), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_data", 64'(data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_health", 64'(health_fail), 64'(0));
    reset = 1'b0;
    tick();

    // First word: static 0x01 gives all ones; the health build would trip on that, so it toggles.
`ifdef RNG_CTRL_HEALTH_EN
    mode_a = 2;
`else
    mode_a = 1;
`endif
    ready = 1'b1;
    start_run(3'b101, e0);
    run_word(mode_a, 8'h01, exp_w);
    wait_valid("first_valid", SD + 8);
    lat = cyc - e0 + 1;
    $display("first word latency=%0d cycles data=%h", lat, data);
    chk("first_latency_window", 64'(lat >= LAT - 2 && lat <= LAT + 2), 64'(1));
    chk("first_data", 64'(data), 64'(exp_w));
    tick();
    chk("valid_drop_after_accept", 64'(valid), 64'(0));
    chk("sel_unchanged", 64'(rng_sel), 64'(3'b101));

    // Toggling oscillator with a 100-cycle consumer stall.
    ready = 1'b0;
    run_word(2, 8'h00, exp_w);
    wait_valid("toggle_valid", SD + 8);
    chk("toggle_data", 64'(data), 64'(32'h5555_5555));
    bad = 0;
    repeat (100) begin
      rng_in = 8'($urandom);
      tick();
      if (valid !== 1'b1 || data !== exp_w) bad++;
    end
    $display("toggle word data=%h held for 100 stalled cycles", data);
    chk("stall_hold", 64'(bad), 64'(0));
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("one_word_per_handshake", 64'(valid), 64'(0));

    // Random words with random stalls; the last one drops enable while offered.
    for (int n = 0; n < 6; n++) begin
      run_word(0, 8'h00, exp_w);
      wait_valid("rand_valid", SD + 8);
      $display("random word %0d data=%h exp=%h", n, data, exp_w);
      chk("rand_data", 64'(data), 64'(exp_w));
      stall = int'($urandom_range(0, 20));
      bad = 0;
      for (int s = 0; s < stall; s++) begin
        if (n == 5 && s == 0) enable = 1'b0;
        tick();
        if (valid !== 1'b1 || data !== exp_w) bad++;
      end
      if (n == 5) enable = 1'b0;
      chk("rand_stall_hold", 64'(bad), 64'(0));
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("rand_valid_drop", 64'(valid), 64'(0));
    end
    chk("idle_after_late_disable", 64'(busy), 64'(0));
    chk("en_off_after_late_disable", 64'(rng_en), 64'(0));

    // Abort mid-collection, then a fresh run must repeat the full warm-up.
    rng_in = 8'h5a;
    start_run(3'b010, e0);
    repeat (300 - WU - 1) tick();
    enable = 1'b0;
    tick();
    tick();
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_rng_en", 64'(rng_en), 64'(0));
    bad = 0;
    repeat (900) begin
      tick();
      if (valid === 1'b1) bad++;
    end
    chk("abort_no_valid", 64'(bad), 64'(0));
    start_run(3'b011, e0);
    run_word(0, 8'h00, exp_w);
    wait_valid("rerun_valid", SD + 8);
    lat = cyc - e0 + 1;
    $display("rerun word latency=%0d cycles data=%h", lat, data);
    chk("rerun_latency_window", 64'(lat >= LAT - 2 && lat <= LAT + 2), 64'(1));
    chk("rerun_data", 64'(data), 64'(exp_w));

    // Reset while a word is being offered.
    reset = 1'b1;
    tick();
    chk("rst_out_valid", 64'(valid), 64'(0));
    chk("rst_out_rng_en", 64'(rng_en), 64'(0));
    chk("rst_out_data", 64'(data), 64'(0));
    chk("rst_out_busy", 64'(busy), 64'(0));
    reset  = 1'b0;
    enable = 1'b0;
    tick();

    // Stuck-at-zero oscillators.
    rng_in = 8'h00;
    ready  = 1'b1;
    start_run(3'b001, e0);
`ifdef RNG_CTRL_HEALTH_EN
    repeat ((RPT - 2) * SD) tick();
    chk("health_not_yet", 64'(health_fail), 64'(0));
    repeat (3 * SD) tick();
    chk("health_set", 64'(health_fail), 64'(1));
    bad = 0;
    repeat (2 * W * SD) begin
      tick();
      if (valid === 1'b1) bad++;
    end
    chk("health_no_valid", 64'(bad), 64'(0));
    chk("health_stays_collect", 64'(busy), 64'(1));
    enable = 1'b0;
    tick();
    tick();
    chk("health_idle_on_disable", 64'(busy), 64'(0));
    chk("health_sticky", 64'(health_fail), 64'(1));
`else
    run_word(1, 8'h00, exp_w);
    wait_valid("zero_valid", SD + 8);
    chk("zero_data", 64'(data), 64'(exp_w));
    chk("no_health_flag", 64'(health_fail), 64'(0));
    enable = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
